// File: rtl/bus_timer_pkg.sv
// bus_timer shared constants: register offsets, CTRL bit positions,
// reset values and the CTRL readback packer.
package bus_timer_pkg;

    localparam logic [1:0] OFF_CTRL     = 2'd0;
    localparam logic [1:0] OFF_PRESCALE = 2'd1;
    localparam logic [1:0] OFF_COUNT    = 2'd2;
    localparam logic [1:0] OFF_COMPARE  = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_AR    = 1;
    localparam int CTRL_IE    = 2;
    localparam int CTRL_MATCH = 8;

    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

    function automatic logic [31:0] ctrl_word(
        input logic en,
        input logic ar,
        input logic ie,
        input logic match
    );
        logic [31:0] w;
        w             = '0;
        w[CTRL_EN]    = en;
        w[CTRL_AR]    = ar;
        w[CTRL_IE]    = ie;
        w[CTRL_MATCH] = match;
        return w;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: one-cycle tick every (presc+1) enabled cycles.
// load restarts the divider from zero.
module timer_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt_q;
    logic [PRESC_W-1:0] pcnt_d;

    assign tick = en && (pcnt_q == presc);

    always_comb begin
        pcnt_d = pcnt_q;
        if (load) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped timer/counter on the external CPU data bus:
// decode, registers, zero-latency read mux, compare and level irq.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
    parameter int          PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        cs,
    input  logic        wr_rd,
    input  logic [31:0] data_bus_write,
    output logic [31:0] data_bus_read,
    output logic        irq
);

    logic               hit;
    logic [1:0]         off;
    logic               wr_ctrl;
    logic               wr_presc;
    logic               wr_count;
    logic               wr_cmp;
    logic               tick;
    logic               cmp_hit;
    logic               unused_addr;

    logic               en_q, en_d;
    logic               ar_q, ar_d;
    logic               ie_q, ie_d;
    logic               match_q, match_d;
    logic               irq_q, irq_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        cmp_q, cmp_d;

    assign hit         = cs && (addr[31:4] == BASE_ADDR[31:4]);
    assign off         = addr[3:2];
    assign unused_addr = ^addr[1:0];

    assign wr_ctrl  = hit && wr_rd && (off == OFF_CTRL);
    assign wr_presc = hit && wr_rd && (off == OFF_PRESCALE);
    assign wr_count = hit && wr_rd && (off == OFF_COUNT);
    assign wr_cmp   = hit && wr_rd && (off == OFF_COMPARE);

    timer_prescaler #(
        .PRESC_W(PRESC_W)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (en_q),
        .load (wr_presc),
        .presc(presc_q),
        .tick (tick)
    );

    assign cmp_hit = tick && (count_q == cmp_q);

    always_comb begin
        en_d    = en_q;
        ar_d    = ar_q;
        ie_d    = ie_q;
        presc_d = presc_q;
        cmp_d   = cmp_q;
        count_d = count_q;
        if (wr_ctrl) begin
            en_d = data_bus_write[CTRL_EN];
            ar_d = data_bus_write[CTRL_AR];
            ie_d = data_bus_write[CTRL_IE];
        end
        if (wr_presc) begin
            presc_d = data_bus_write[PRESC_W-1:0];
        end
        if (wr_cmp) begin
            cmp_d = data_bus_write;
        end
        // A CPU write to COUNT overrides the tick update in the same cycle
        if (wr_count) begin
            count_d = data_bus_write;
        end else if (tick) begin
            count_d = (cmp_hit && ar_q) ? 32'd0 : count_q + 32'd1;
        end
        match_d = (match_q && !(wr_ctrl && data_bus_write[CTRL_MATCH]))
                  || cmp_hit;
        irq_d   = match_d && ie_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= 1'b0;
            ar_q    <= 1'b0;
            ie_q    <= 1'b0;
            match_q <= 1'b0;
            irq_q   <= 1'b0;
            presc_q <= '0;
            count_q <= '0;
            cmp_q   <= COMPARE_RST;
        end else begin
            en_q    <= en_d;
            ar_q    <= ar_d;
            ie_q    <= ie_d;
            match_q <= match_d;
            irq_q   <= irq_d;
            presc_q <= presc_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
        end
    end

    always_comb begin
        data_bus_read = '0;
        if (hit && !wr_rd) begin
            case (off)
                OFF_CTRL:     data_bus_read = ctrl_word(en_q, ar_q, ie_q, match_q);
                OFF_PRESCALE: data_bus_read = 32'(presc_q);
                OFF_COUNT:    data_bus_read = count_q;
                default:      data_bus_read = cmp_q;
            endcase
        end
    end

    assign irq = irq_q;

endmodule
